uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 127 ++++++++++++
 tb/tb_uart_tx_framer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first payload, optional even/odd parity, stop bit.
// Serial line and Busy are registered and decoded from the next state.
module uart_tx_framer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    tx_out_q, tx_out_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic                    parity_bit;

    assign parity_bit = (^data_q) ^ par_typ_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    accept = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (Data_Valid) begin
                    accept = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A request in STOP chains straight into the next start bit
        if (accept) begin
            state_d   = START;
            cnt_d     = '0;
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
        end
    end

    always_comb begin
        tx_out_d = 1'b1;
        busy_d   = 1'b1;
        case (state_d)
            IDLE:    busy_d   = 1'b0;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = data_q[cnt_d];
            PARITY:  tx_out_d = parity_bit;
            STOP:    tx_out_d = 1'b1;
            default: busy_d   = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: table of frames with hand-computed serial bit patterns,
// plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_framer;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks;
    int failures;

    // exp[i] is the line value in cycle i of the frame (cycle 0 = start bit)
    typedef struct {
        string      name;
        logic       par_en;
        logic       par_typ;
        logic [7:0] data;
        int         nbits;
        logic [0:10] exp;
    } vec_t;

    vec_t vecs[7];

    uart_tx_framer #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int idx, input logic exp_tx, input logic exp_busy);
        checks++;
        if (TX_OUT !== exp_tx) begin
            failures++;
            $display("[TB] FAIL %s[%0d] TX_OUT: got %b expected %b", name, idx, TX_OUT, exp_tx);
        end
        checks++;
        if (Busy !== exp_busy) begin
            failures++;
            $display("[TB] FAIL %s[%0d] Busy: got %b expected %b", name, idx, Busy, exp_busy);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        P_DATA     = v.data;
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
        Data_Valid = 1'b1;
    endtask

    // Called at the falling edge where the start bit of v is on the line.
    // Inputs are scrambled to prove the frame uses latched values, and a
    // stray request mid-frame must be ignored.
    task automatic playFrame(input vec_t v, input bit chain, input vec_t nxt);
        Data_Valid = 1'b0;
        P_DATA     = ~v.data;
        PAR_EN     = ~v.par_en;
        PAR_TYP    = ~v.par_typ;
        for (int i = 0; i < v.nbits; i++) begin
            checkOutput(v.name, i, v.exp[i], 1'b1);
            if (i == 3) Data_Valid = 1'b1;
            if (i == 4) Data_Valid = 1'b0;
            if (chain && i == v.nbits - 1) applyStimulus(nxt);
            @(negedge CLK);
        end
        if (!chain) checkOutput({v.name, "_idle"}, 0, 1'b1, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        RST        = 1'b1;
        Data_Valid = 1'b1;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        vecs[0] = '{"a5_even",   1'b1, 1'b0, 8'hA5, 11, 11'b01010010101};
        vecs[1] = '{"01_odd",    1'b1, 1'b1, 8'h01, 11, 11'b01000000001};
        vecs[2] = '{"01_even",   1'b1, 1'b0, 8'h01, 11, 11'b01000000011};
        vecs[3] = '{"ff_nopar",  1'b0, 1'b0, 8'hFF, 10, 11'b01111111111};
        vecs[4] = '{"3c_even",   1'b1, 1'b0, 8'h3C, 11, 11'b00011110001};
        vecs[5] = '{"55_nopar",  1'b0, 1'b1, 8'h55, 10, 11'b01010101011};
        vecs[6] = '{"80_odd",    1'b1, 1'b1, 8'h80, 11, 11'b00000000101};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset", 0, 1'b1, 1'b0);
        RST        = 1'b0;
        Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("idle", i, 1'b1, 1'b0);
        end

        $display("[TB] table-driven frames");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k]);
            @(negedge CLK);
            playFrame(vecs[k], 1'b0, vecs[k]);
        end

        $display("[TB] back-to-back frames");
        applyStimulus(vecs[0]);
        @(negedge CLK);
        playFrame(vecs[0], 1'b1, vecs[4]);
        playFrame(vecs[4], 1'b0, vecs[4]);

        $display("[TB] reset during data bit 3");
        applyStimulus(vecs[0]);
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("pre_rst", i, vecs[0].exp[i], 1'b1);
            if (i < 4) @(negedge CLK);
        end
        RST        = 1'b1;
        Data_Valid = 1'b1;
        P_DATA     = 8'h55;
        @(negedge CLK);
        checkOutput("rst_abort", 0, 1'b1, 1'b0);
        RST        = 1'b0;
        Data_Valid = 1'b0;
        @(negedge CLK);
        checkOutput("post_rst_idle", 0, 1'b1, 1'b0);
        applyStimulus(vecs[5]);
        @(negedge CLK);
        playFrame(vecs[5], 1'b0, vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
